xbus_master: RTL
================

Name: xbus_master

Overview:
- Initiator end of the xbus: converts a valid/ready load/store request from the core or debug logic into one xbus access.
- Drives cs/we/be/addr/wdata to peripherals such as the switch/LED register, GPIO and timers.
- Handles byte/half/word lane steering and read-data extraction with sign/zero extension.
- Returns a single response with a misaligned-access error flag.

Parameters:
RD_WAIT, 0, extra cycles cs is held on reads before rdata is sampled (0 = combinational responder)
ADDR_W, 32, xbus address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 byte, 1 half, 2 word, 3 reserved (treated as misaligned)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  response consumed when resp_valid && resp_ready
resp_rdata  output  32  extended load data (0 for stores/errors)
resp_err  output  1  misaligned or reserved size; no bus cycle issued
xbus_cs  output  1  chip select
xbus_we  output  1  write enable
xbus_be  output  4  byte enables
xbus_addr  output  ADDR_W  word address: req_addr with [1:0] forced to 0
xbus_wdata  output  32  lane-steered store data
xbus_rdata  input  32  responder read data

Behaviour:
- Reset (async, rst_n low): state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, xbus_cs=0, xbus_we=0, xbus_be=0, xbus_addr=0, xbus_wdata=0.
- Reset mid-access abandons the access; no response is produced.
- Single outstanding request. req_ready=1 only in IDLE.

State machine:
- IDLE: on accept, latch request into registers.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 3) -> RESP with err=1.
  - Otherwise -> BUS.
- BUS:
  - xbus_cs=1; xbus_we, xbus_be, xbus_addr, xbus_wdata driven from latched registers. All xbus outputs are registered-state-derived, not combinational from req_*.
  - Store: exactly 1 cs cycle, then RESP.
  - Load: cs held 1+RD_WAIT cycles; wait counter counts from 0 to RD_WAIT. xbus_rdata is sampled on the clock edge ending the last cs cycle, then RESP.
- RESP: resp_valid=1; hold resp_rdata/resp_err stable until resp_ready; then IDLE.
  - If resp_ready is already high on entry, RESP lasts one cycle.
  - Next accept is no earlier than the cycle after leaving RESP.
- Outside BUS: xbus_cs=0, xbus_we=0, xbus_be=0.
- Error responses never assert xbus_cs.

Lane steering (a = addr[1:0]):
- Byte: be = 1<<a; wdata = {4{req_wdata[7:0]}}.
- Half: be = 4'b0011 << a; wdata = {2{req_wdata[15:0]}}.
- Word: be = 4'b1111; wdata = req_wdata.

Load extract:
- Byte: lane a of rdata, bits [8a+7:8a], extended.
- Half: bits [8a+15:8a], extended.
- Word: as-is.
- Extension per req_unsigned.

Throughput: store with resp_ready high = 3 cycles accept-to-accept (IDLE, BUS, RESP); load = 3+RD_WAIT.

Test Plan:
- Word store addr 0x1000_0000, data 0x0000_00A5 -> one cycle cs=1, we=1, be=1111, addr=0x1000_0000, wdata=0x0000_00A5; resp_valid next cycle, err=0.
- Byte store addr 0x1000_0002, data 0x3C -> be=0100, wdata=0x3C3C3C3C, one cs cycle.
- Byte load addr 0x1000_0001 with rdata=0x0000_8000 -> resp_rdata signed=0xFFFF_FF80, unsigned=0x0000_0080. Half load addr 0x1000_0002 with rdata=0x8001_0000 -> signed 0xFFFF_8001.
- RD_WAIT=2 word load -> cs high exactly 3 cycles; rdata changed before the final cycle is ignored; the final-cycle value is returned.
- Half store addr 0x...1 and word load addr 0x...2 -> resp_err=1, resp_rdata=0, xbus_cs never asserted.
- Backpressure: resp_ready low 5 cycles -> resp_valid/rdata stable, req_ready=0. Reset asserted during BUS with RD_WAIT=3 -> cs drops immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/xbus_master_if.sv
// Bundle of request, response and xbus signals for xbus_master.
// master modport is the DUT view; slave is the core/peripheral side.
interface xbus_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              xbus_cs;
  logic              xbus_we;
  logic [3:0]        xbus_be;
  logic [ADDR_W-1:0] xbus_addr;
  logic [31:0]       xbus_wdata;
  logic [31:0]       xbus_rdata;

  modport master (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output xbus_cs, xbus_we, xbus_be,
    output xbus_addr, xbus_wdata,
    input  xbus_rdata
  );

  modport slave (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  xbus_cs, xbus_we, xbus_be,
    input  xbus_addr, xbus_wdata,
    output xbus_rdata
  );
endinterface

// File: rtl/xbus_master.sv
// xbus initiator: one load/store request becomes one xbus access,
// with lane steering, load extension and misalignment errors.
module xbus_master #(
  parameter int RD_WAIT = 0,
  parameter int ADDR_W  = 32
) (
  input logic           clk,
  input logic           rst_n,
  xbus_master_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW =
    (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

  logic [1:0]        state;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [CW-1:0]     cnt;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [1:0]  lane;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        misal;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        last;
  logic        cs;

  assign lane = bus.req_addr[1:0];

  always_comb begin
    be_n    = 4'b0000;
    wdata_n = 32'h0;
    misal   = 1'b1;
    unique case (1'b1)
      bus.req_size == 2'd0: begin
        be_n    = 4'b0001 << lane;
        wdata_n = {4{bus.req_wdata[7:0]}};
        misal   = 1'b0;
      end
      bus.req_size == 2'd1: begin
        be_n    = 4'b0011 << lane;
        wdata_n = {2{bus.req_wdata[15:0]}};
        misal   = lane[0];
      end
      bus.req_size == 2'd2: begin
        be_n    = 4'b1111;
        wdata_n = bus.req_wdata;
        misal   = |lane;
      end
      default: begin
        misal = 1'b1;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  always_comb begin
    sh  = bus.xbus_rdata >> {lane_q, 3'b000};
    ext = sh;
    unique case (1'b1)
      size_q == 2'd0:
        ext = {{24{~uns_q & sh[7]}}, sh[7:0]};
      size_q == 2'd1:
        ext = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default:
        ext = sh;
    endcase
  end

  assign last = we_q | (cnt == CW'(RD_WAIT));
  assign cs   = (state == BUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      lane_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      cnt     <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            lane_q  <= lane;
            addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= wdata_n;
            be_q    <= be_n;
            cnt     <= '0;
            rdata_q <= 32'h0;
            err_q   <= misal;
            state   <= misal ? RESP : BUS;
          end
        end
        BUS: begin
          if (last) begin
            if (!we_q) rdata_q <= ext;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.xbus_cs    = cs;
  assign bus.xbus_we    = cs & we_q;
  assign bus.xbus_be    = cs ? be_q : 4'b0000;
  assign bus.xbus_addr  = addr_q;
  assign bus.xbus_wdata = wdata_q;

endmodule
